// File: rtl/pz_round_ctrl.sv
// ---------------------------------------------------------------------------
// pz_round_ctrl
// Game sequencer for the punch-zombie board. Picks which of three holes shows
// a zombie, times each appearance and the dark gap that follows, counts hits
// and misses, and ends the game after MAX_MISS timeouts.
//
// Ports
//   clk        in   1        system clock, posedge
//   rst        in   1        asynchronous active-high reset
//   start      in   1        1-cycle pulse, begins a game from IDLE or OVER
//   hit        in   1        1-cycle pulse from the button/zombie detector
//   mole       out  3        one-hot visible zombie, 3'b000 when none
//   score      out  SCORE_W  hits this game, saturating
//   misses     out  4        timeouts this game
//   playing    out  1        high while in SPAWN/ACTIVE/GAP
//   game_over  out  1        high while in OVER
//
// Optional feature macro: PZ_SPEEDUP_EN
//   When defined, every 8th hit shortens the visible window by one tick
//   (floor MOLE_TICKS/4, minimum 1). When undefined, every zombie is shown
//   for MOLE_TICKS ticks and no window register exists.
// ---------------------------------------------------------------------------
module pz_round_ctrl #(
   parameter int unsigned TICK_DIV   = 50000,
   parameter int unsigned MOLE_TICKS = 800,
   parameter int unsigned GAP_TICKS  = 200,
   parameter int unsigned MAX_MISS   = 3,
   parameter int unsigned SCORE_W    = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               hit,
   output logic [2:0]         mole,
   output logic [SCORE_W-1:0] score,
   output logic [3:0]         misses,
   output logic               playing,
   output logic               game_over
);

   localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned T_MAX = (MOLE_TICKS > GAP_TICKS) ? MOLE_TICKS : GAP_TICKS;
   localparam int unsigned TMR_W = $clog2(T_MAX + 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SPAWN  = 3'd1,
      ST_ACTIVE = 3'd2,
      ST_GAP    = 3'd3,
      ST_OVER   = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic [PRE_W-1:0]     pre_q, pre_d;
   logic [TMR_W-1:0]     timer_q, timer_d;
   logic [7:0]           lfsr_q, lfsr_d;
   logic [2:0]           mole_d;
   logic [SCORE_W-1:0]   score_d;
   logic [3:0]           misses_d;
   logic                 playing_d;
   logic                 game_over_d;
   logic                 tick_c;
   logic [3:0]           miss_inc_c;
   logic [TMR_W-1:0]     spawn_load_c;

`ifdef PZ_SPEEDUP_EN
   localparam int unsigned WIN_MIN = ((MOLE_TICKS / 4) >= 1) ? (MOLE_TICKS / 4) : 1;
   logic [TMR_W-1:0]     window_q, window_d;
   assign spawn_load_c = window_q;
`else
   assign spawn_load_c = TMR_W'(MOLE_TICKS);
`endif

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         pre_q     <= '0;
         timer_q   <= '0;
         lfsr_q    <= 8'hA5;
         mole      <= 3'b000;
         score     <= '0;
         misses    <= 4'd0;
         playing   <= 1'b0;
         game_over <= 1'b0;
`ifdef PZ_SPEEDUP_EN
         window_q  <= TMR_W'(MOLE_TICKS);
`endif
      end else begin
         state_q   <= state_d;
         pre_q     <= pre_d;
         timer_q   <= timer_d;
         lfsr_q    <= lfsr_d;
         mole      <= mole_d;
         score     <= score_d;
         misses    <= misses_d;
         playing   <= playing_d;
         game_over <= game_over_d;
`ifdef PZ_SPEEDUP_EN
         window_q  <= window_d;
`endif
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      mole_d      = mole;
      score_d     = score;
      misses_d    = misses;
`ifdef PZ_SPEEDUP_EN
      window_d    = window_q;
`endif
      tick_c      = (pre_q == PRE_W'(TICK_DIV - 1));
      pre_d       = tick_c ? '0 : pre_q + PRE_W'(1);
      miss_inc_c  = misses + 4'd1;
      // Fibonacci LFSR, taps 8,6,5,4; free-running in every state
      lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      playing_d   = 1'b0;
      game_over_d = 1'b0;

      case (state_q)
         ST_IDLE, ST_OVER: begin
            if (start) begin
               score_d  = '0;
               misses_d = 4'd0;
`ifdef PZ_SPEEDUP_EN
               window_d = TMR_W'(MOLE_TICKS);
`endif
               state_d  = ST_SPAWN;
            end
         end

         ST_SPAWN: begin
            // Hole index 3 does not exist: retry on the next LFSR value
            if (lfsr_q[1:0] != 2'd3) begin
               mole_d  = 3'b001 << lfsr_q[1:0];
               timer_d = spawn_load_c;
               state_d = ST_ACTIVE;
            end
         end

         ST_ACTIVE: begin
            // A hit on the expiry cycle takes priority over the timeout
            if (hit) begin
               if (score != '1) begin
                  score_d = score + SCORE_W'(1);
`ifdef PZ_SPEEDUP_EN
                  if ((score_d[2:0] == 3'd0) && (window_q > TMR_W'(WIN_MIN))) begin
                     window_d = window_q - TMR_W'(1);
                  end
`endif
               end
               mole_d  = 3'b000;
               timer_d = TMR_W'(GAP_TICKS);
               state_d = ST_GAP;
            end else if (tick_c) begin
               if (timer_q == TMR_W'(1)) begin
                  misses_d = miss_inc_c;
                  mole_d   = 3'b000;
                  if (miss_inc_c == 4'(MAX_MISS)) begin
                     timer_d = '0;
                     state_d = ST_OVER;
                  end else begin
                     timer_d = TMR_W'(GAP_TICKS);
                     state_d = ST_GAP;
                  end
               end else begin
                  timer_d = timer_q - TMR_W'(1);
               end
            end
         end

         ST_GAP: begin
            if (tick_c) begin
               if (timer_q == TMR_W'(1)) begin
                  timer_d = '0;
                  state_d = ST_SPAWN;
               end else begin
                  timer_d = timer_q - TMR_W'(1);
               end
            end
         end

         default: begin
            mole_d  = 3'b000;
            state_d = ST_IDLE;
         end
      endcase

      // Every timed phase starts from a fresh prescaler
      if (state_d != state_q) begin
         pre_d = '0;
      end

      playing_d   = (state_d == ST_SPAWN) || (state_d == ST_ACTIVE) || (state_d == ST_GAP);
      game_over_d = (state_d == ST_OVER);
   end

endmodule

// File: tb/tb_pz_round_ctrl.sv
// Testbench for pz_round_ctrl: directed table, hand-written corner sequences
// and randomized start/hit stimulus compared against a cycle-count game model.
module tb_pz_round_ctrl;

   localparam int TICK_DIV   = 4;
   localparam int MOLE_TICKS = 3;
   localparam int GAP_TICKS  = 2;
   localparam int MAX_MISS   = 3;
   localparam int SCORE_W    = 8;
   localparam int ACT_CYC    = MOLE_TICKS * TICK_DIV;
   localparam int GAP_CYC    = GAP_TICKS * TICK_DIV;
   localparam int SCORE_MAX  = (1 << SCORE_W) - 1;
   localparam int VW         = 3 + SCORE_W + 4 + 2;
`ifdef PZ_SPEEDUP_EN
   localparam int WIN_MIN    = ((MOLE_TICKS / 4) >= 1) ? (MOLE_TICKS / 4) : 1;
`endif

   logic               clk   = 1'b0;
   logic               rst   = 1'b0;
   logic               start = 1'b0;
   logic               hit   = 1'b0;
   logic [2:0]         mole;
   logic [SCORE_W-1:0] score;
   logic [3:0]         misses;
   logic               playing;
   logic               game_over;

   int checks   = 0;
   int failures = 0;

   pz_round_ctrl #(
      .TICK_DIV  (TICK_DIV),
      .MOLE_TICKS(MOLE_TICKS),
      .GAP_TICKS (GAP_TICKS),
      .MAX_MISS  (MAX_MISS),
      .SCORE_W   (SCORE_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .hit      (hit),
      .mole     (mole),
      .score    (score),
      .misses   (misses),
      .playing  (playing),
      .game_over(game_over)
   );

   always #5 clk = ~clk;

   // Game model: phases measured directly in clock cycles remaining
   typedef enum int {M_IDLE, M_SPAWN, M_ACTIVE, M_GAP, M_OVER} mphase_t;
   mphase_t    m_ph;
   int         m_rem, m_score, m_misses, m_win;
   logic [7:0] m_lfsr;
   logic [2:0] m_mole;

   task automatic model_reset();
      m_ph = M_IDLE; m_rem = 0; m_score = 0; m_misses = 0;
      m_win = MOLE_TICKS; m_lfsr = 8'hA5; m_mole = 3'b000;
   endtask

   task automatic model_step(input logic s, input logic h);
      logic [7:0] l;
      l = m_lfsr;
      m_lfsr = {l[6:0], ^(l & 8'b1011_1000)};
      case (m_ph)
         M_IDLE, M_OVER: if (s) begin
            m_score = 0; m_misses = 0; m_win = MOLE_TICKS; m_ph = M_SPAWN;
         end
         M_SPAWN: if (l[1:0] != 2'd3) begin
            m_mole = 3'b001 << l[1:0];
            m_rem  = m_win * TICK_DIV;
            m_ph   = M_ACTIVE;
         end
         M_ACTIVE: begin
            if (h) begin
               if (m_score < SCORE_MAX) begin
                  m_score++;
`ifdef PZ_SPEEDUP_EN
                  if ((m_score % 8) == 0 && m_win > WIN_MIN) m_win--;
`endif
               end
               m_mole = 3'b000; m_rem = GAP_CYC; m_ph = M_GAP;
            end else if (m_rem == 1) begin
               m_misses++;
               m_mole = 3'b000;
               if (m_misses == MAX_MISS) m_ph = M_OVER;
               else begin m_rem = GAP_CYC; m_ph = M_GAP; end
            end else m_rem--;
         end
         M_GAP: if (m_rem == 1) m_ph = M_SPAWN; else m_rem--;
         default: m_ph = M_IDLE;
      endcase
   endtask

   task automatic check_model(input string name);
      logic [VW-1:0] act, exp;
      logic          e_play, e_over;
      e_play = (m_ph == M_SPAWN) || (m_ph == M_ACTIVE) || (m_ph == M_GAP);
      e_over = (m_ph == M_OVER);
      act = {mole, score, misses, playing, game_over};
      exp = {m_mole, SCORE_W'(m_score), 4'(m_misses), e_play, e_over};
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s @%0t: dut mole=%b score=%0d misses=%0d playing=%b over=%b, model mole=%b score=%0d misses=%0d playing=%b over=%b",
                  name, $time, mole, score, misses, playing, game_over,
                  m_mole, m_score, m_misses, e_play, e_over);
      end
   endtask

   task automatic check_eq(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi_b);
      checks++;
      if (act < lo || act > hi_b) begin
         failures++;
         $display("FAIL %s @%0t: got %0d, expected %0d..%0d", name, $time, act, lo, hi_b);
      end
   endtask

   // One clock: drive inputs, advance model, sample #1 after the edge
   task automatic cycle(input logic s, input logic h);
      start = s; hit = h;
      model_step(s, h);
      @(posedge clk); #1;
      start = 1'b0; hit = 1'b0;
      check_model("model");
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; hit = 1'b0;
      #1;
      model_reset();
      check_model("async_reset");
      check_eq("reset_outputs_zero", int'({mole, score, misses, playing, game_over}), 0);
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic wait_mole(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 64; i++) begin
         if (mole != 3'b000) begin ok = 1'b1; break; end
         cycle(1'b0, 1'b0);
      end
      check_eq("wait_mole_in_time", int'(ok), 1);
   endtask

   task automatic visible_width(output int w);
      w = 0;
      for (int i = 0; i < 64 && mole != 3'b000; i++) begin
         w++;
         cycle(1'b0, 1'b0);
      end
   endtask

   typedef struct {
      logic s;
      logic h;
      logic play;
      logic over;
      int   sc;
      int   ms;
   } vec_t;
   vec_t tbl[6];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit ok;
      int hi_n, dark, d, w;
      bit seen;

      tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0};  // hit in IDLE ignored
      tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
      tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 0, 0};  // start wins over hit
      tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 0};
      tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 0};  // start while playing ignored
      tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 0};

      #2;
      do_reset();
      repeat (100) cycle(1'b0, 1'b0);
      check_eq("idle_100_quiet", int'({mole, score, misses, playing, game_over}), 0);

      for (int i = 0; i < 6; i++) begin
         cycle(tbl[i].s, tbl[i].h);
         checks++;
         if (playing !== tbl[i].play || game_over !== tbl[i].over ||
             int'(score) != tbl[i].sc || int'(misses) != tbl[i].ms) begin
            failures++;
            $display("FAIL table[%0d]: got playing=%b over=%b score=%0d misses=%0d, expected %b %b %0d %0d",
                     i, playing, game_over, score, misses, tbl[i].play, tbl[i].over, tbl[i].sc, tbl[i].ms);
         end
      end

      // No hits: three full-length moles, then OVER
      do_reset();
      cycle(1'b1, 1'b0);
      hi_n = 0; dark = 0; seen = 1'b0;
      for (int i = 0; i < 300; i++) begin
         cycle(1'b0, 1'b0);
         if (mole != 3'b000) begin
            if (hi_n == 0 && seen) check_range("dark_between_moles", dark, GAP_CYC + 1, GAP_CYC + 8);
            check_eq("mole_onehot", $countones(mole), 1);
            hi_n++; dark = 0;
         end else begin
            if (hi_n != 0) begin check_eq("mole_width", hi_n, ACT_CYC); seen = 1'b1; end
            hi_n = 0;
            if (playing) dark++;
         end
         if (game_over) break;
      end
      check_eq("over_game_over", int'(game_over), 1);
      check_eq("over_misses", int'(misses), MAX_MISS);
      check_eq("over_playing", int'(playing), 0);
      check_eq("over_mole", int'(mole), 0);

      // Hit 5 clk after rise, then dark gap
      do_reset();
      cycle(1'b1, 1'b0);
      wait_mole(ok);
      repeat (4) cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b1);
      check_eq("hit_score", int'(score), 1);
      check_eq("hit_mole_cleared", int'(mole), 0);
      check_eq("hit_misses", int'(misses), 0);
      dark = 0;
      for (int i = 0; i < 40 && mole == 3'b000; i++) begin dark++; cycle(1'b0, 1'b0); end
      check_range("dark_after_hit", dark, GAP_CYC + 1, GAP_CYC + 8);

      // Hit on the exact expiry cycle, then hits during GAP
      repeat (ACT_CYC - 1) cycle(1'b0, 1'b0);
      check_eq("still_visible_last_cycle", int'(mole != 3'b000), 1);
      cycle(1'b0, 1'b1);
      check_eq("expiry_hit_score", int'(score), 2);
      check_eq("expiry_hit_misses", int'(misses), 0);
      repeat (3) cycle(1'b0, 1'b1);
      check_eq("gap_hits_ignored", int'(score), 2);

      // Randomized start/hit traffic
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         cycle(1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 7) == 0));
      end

      // Score saturation and restart from OVER
      do_reset();
      cycle(1'b1, 1'b0);
      for (int n = 0; n < 400 && int'(score) < SCORE_MAX - 1; n++) begin
         wait_mole(ok);
         if (!ok) break;
         d = int'($urandom_range(0, ACT_CYC - 1));
         repeat (d) cycle(1'b0, 1'b0);
         cycle(1'b0, 1'b1);
      end
      check_eq("score_fe", int'(score), SCORE_MAX - 1);
      wait_mole(ok); cycle(1'b0, 1'b1);
      check_eq("score_ff", int'(score), SCORE_MAX);
      wait_mole(ok); cycle(1'b0, 1'b1);
      check_eq("score_saturated", int'(score), SCORE_MAX);
      for (int i = 0; i < 300 && !game_over; i++) cycle(1'b0, 1'b0);
      check_eq("sat_game_over", int'(game_over), 1);
      check_eq("sat_score_frozen", int'(score), SCORE_MAX);
      cycle(1'b1, 1'b1);
      check_eq("restart_score", int'(score), 0);
      check_eq("restart_misses", int'(misses), 0);
      check_eq("restart_playing", int'(playing), 1);

      // Reset while a mole is visible
      wait_mole(ok);
      repeat (2) cycle(1'b0, 1'b0);
      do_reset();
      repeat (5) cycle(1'b0, 1'b0);

`ifdef PZ_SPEEDUP_EN
      cycle(1'b1, 1'b0);
      repeat (8) begin wait_mole(ok); cycle(1'b0, 1'b1); end
      wait_mole(ok);
      visible_width(w);
      check_eq("speedup_width_8", w, (MOLE_TICKS - 1) * TICK_DIV);
      repeat (16) begin wait_mole(ok); cycle(1'b0, 1'b1); end
      wait_mole(ok);
      visible_width(w);
      check_eq("speedup_width_floor", w, WIN_MIN * TICK_DIV);
`else
      cycle(1'b1, 1'b0);
      repeat (8) begin wait_mole(ok); cycle(1'b0, 1'b1); end
      wait_mole(ok);
      visible_width(w);
      check_eq("fixed_width_after_8", w, ACT_CYC);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
